// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - two-word instruction fetch unit with pc redirect and discard of in-flight reads
module instr_fetch #(
    parameter logic [7:0] RESET_PC = 8'd0
) (
    input  logic        clk,
    input  logic        reset,
    output logic [7:0]  mem_address,
    output logic        mem_rwn,
    output logic        mem_start,
    input  logic        mem_ready,
    input  logic [15:0] mem_data,
    input  logic        pc_load,
    input  logic [7:0]  pc_target,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [7:0]  instr_pc,
    input  logic        instr_accept
);

    typedef enum logic [2:0] {
        REQ_HI  = 3'd0,
        WAIT_HI = 3'd1,
        REQ_LO  = 3'd2,
        WAIT_LO = 3'd3,
        HOLD    = 3'd4
    } state_t;

    state_t      state, state_nx;
    logic [7:0]  pc, pc_nx;
    logic [7:0]  target, target_nx;
    logic [15:0] hi, hi_nx;
    logic [15:0] lo, lo_nx;
    logic        discard, discard_nx;
    logic        lo_phase;
    logic        req_phase;

    // State register; reset returns to a clean fetch at RESET_PC.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= REQ_HI;
            pc      <= RESET_PC;
            target  <= RESET_PC;
            hi      <= 16'd0;
            lo      <= 16'd0;
            discard <= 1'b0;
        end else begin
            state   <= state_nx;
            pc      <= pc_nx;
            target  <= target_nx;
            hi      <= hi_nx;
            lo      <= lo_nx;
            discard <= discard_nx;
        end
    end

    // Next-state: walk the two reads, hold for the decoder, honour redirects.
    // A read already accepted by memory cannot be cancelled, so a redirect in a
    // WAIT state is parked in target and the returning word is thrown away.
    always_comb begin
        state_nx   = state;
        pc_nx      = pc;
        target_nx  = target;
        hi_nx      = hi;
        lo_nx      = lo;
        discard_nx = discard;
        case (state)
            REQ_HI, REQ_LO: begin
                if (pc_load) begin
                    pc_nx    = pc_target;
                    state_nx = REQ_HI;
                end else if (mem_ready) begin
                    state_nx = (state == REQ_HI) ? WAIT_HI : WAIT_LO;
                end
            end
            WAIT_HI, WAIT_LO: begin
                if (mem_ready) begin
                    if (discard || pc_load) begin
                        pc_nx      = pc_load ? pc_target : target;
                        discard_nx = 1'b0;
                        state_nx   = REQ_HI;
                    end else if (state == WAIT_HI) begin
                        hi_nx    = mem_data;
                        state_nx = REQ_LO;
                    end else begin
                        lo_nx    = mem_data;
                        state_nx = HOLD;
                    end
                end else if (pc_load) begin
                    target_nx  = pc_target;
                    discard_nx = 1'b1;
                end
            end
            HOLD: begin
                if (pc_load) begin
                    pc_nx    = pc_target;
                    state_nx = REQ_HI;
                end else if (instr_accept) begin
                    pc_nx    = pc + 8'd2;
                    state_nx = REQ_HI;
                end
            end
            default: state_nx = REQ_HI;
        endcase
    end

    // Outputs: request only into an idle memory and never on a redirect cycle.
    always_comb begin
        lo_phase    = (state == REQ_LO) || (state == WAIT_LO);
        req_phase   = (state == REQ_HI) || (state == REQ_LO);
        mem_address = lo_phase ? (pc + 8'd1) : pc;
        mem_rwn     = 1'b1;
        mem_start   = reset && req_phase && mem_ready && !pc_load;
        instr_valid = (state == HOLD);
        instr       = {hi, lo};
        instr_pc    = pc;
    end

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - randomized self-checking bench for instr_fetch with variable-latency memory
`timescale 1ns/1ps
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  mem_address;
    logic        mem_rwn;
    logic        mem_start;
    logic        mem_ready = 1'b1;
    logic [15:0] mem_data = 16'd0;
    logic        pc_load = 1'b0;
    logic [7:0]  pc_target = 8'd0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [7:0]  instr_pc;
    logic        instr_accept = 1'b0;

    logic [15:0] mem [256];
    logic [1:0]  busy_cnt = 2'd0;
    logic [7:0]  lat_addr = 8'd0;
    logic [7:0]  addr_q [$];
    int          start_viol = 0;
    int          errors = 0;
    int          checks = 0;

    instr_fetch #(.RESET_PC(8'd0)) dut (
        .clk(clk), .reset(reset), .mem_address(mem_address), .mem_rwn(mem_rwn),
        .mem_start(mem_start), .mem_ready(mem_ready), .mem_data(mem_data),
        .pc_load(pc_load), .pc_target(pc_target), .instr_valid(instr_valid),
        .instr(instr), .instr_pc(instr_pc), .instr_accept(instr_accept)
    );

    always #5 clk = ~clk;

    // Memory responder: ready low for addr[1:0]+1 edges after an accepted request.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_ready <= 1'b1;
            mem_data  <= 16'd0;
            busy_cnt  <= 2'd0;
        end else if (mem_start && mem_ready) begin
            mem_ready <= 1'b0;
            busy_cnt  <= mem_address[1:0];
            lat_addr  <= mem_address;
        end else if (!mem_ready) begin
            if (busy_cnt == 2'd0) begin
                mem_ready <= 1'b1;
                mem_data  <= mem[lat_addr];
            end else begin
                busy_cnt <= busy_cnt - 2'd1;
            end
        end
    end

    // Request monitor: record issued addresses and any start into a busy memory.
    always @(posedge clk) begin
        if (reset) begin
            if (mem_start && mem_ready) addr_q.push_back(mem_address);
            if (mem_start && !mem_ready) start_viol++;
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    function automatic int lat(input logic [7:0] p);
        logic [7:0] q;
        q = p + 8'd1;
        return int'(p[1:0]) + int'(q[1:0]) + 6;
    endfunction

    function automatic logic [31:0] word_pair(input logic [7:0] p);
        logic [7:0] q;
        q = p + 8'd1;
        return {mem[p], mem[q]};
    endfunction

    task automatic do_reset();
        reset = 1'b0;
        pc_load = 1'b0;
        instr_accept = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!instr_valid && n < 300);
        if (!instr_valid) n = -1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        @(posedge clk);
        #3;
        checks++; if (mem_start !== 1'b0) begin errors++; $display("FAIL rst_mem_start: got %b expected 0", mem_start); end
        checks++; if (mem_address !== 8'd0) begin errors++; $display("FAIL rst_mem_address: got %h expected 00", mem_address); end
        checks++; if (mem_rwn !== 1'b1) begin errors++; $display("FAIL rst_mem_rwn: got %b expected 1", mem_rwn); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rst_instr_valid: got %b expected 0", instr_valid); end
        checks++; if (instr !== 32'd0) begin errors++; $display("FAIL rst_instr: got %h expected 0", instr); end
        checks++; if (instr_pc !== 8'd0) begin errors++; $display("FAIL rst_instr_pc: got %h expected 00", instr_pc); end
    endtask

    task automatic test_basic();
        int n;
        do_reset();
        instr_accept = 1'b1;
        wait_valid(n);
        checks++; if (n !== 7) begin errors++; $display("FAIL basic_lat0: got %0d edges expected 7", n); end
        checks++; if (instr !== 32'h61400002) begin errors++; $display("FAIL basic_instr0: got %h expected 61400002", instr); end
        checks++; if (instr_pc !== 8'h00) begin errors++; $display("FAIL basic_pc0: got %h expected 00", instr_pc); end
        @(posedge clk); #1;
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL basic_drop: got %b expected 0", instr_valid); end
        wait_valid(n);
        checks++; if (n !== 11) begin errors++; $display("FAIL basic_lat2: got %0d edges expected 11", n); end
        checks++; if (instr !== 32'h694A0002) begin errors++; $display("FAIL basic_instr2: got %h expected 694a0002", instr); end
        checks++; if (instr_pc !== 8'h02) begin errors++; $display("FAIL basic_pc2: got %h expected 02", instr_pc); end
        instr_accept = 1'b0;
    endtask

    task automatic test_stall();
        int n;
        int bad;
        logic [31:0] snap;
        do_reset();
        wait_valid(n);
        checks++; if (n !== 7) begin errors++; $display("FAIL stall_lat: got %0d expected 7", n); end
        snap = instr;
        bad = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (!instr_valid || instr !== snap || instr_pc !== 8'h00 || mem_start !== 1'b0) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL stall_hold: got %0d unstable cycles expected 0", bad); end
        instr_accept = 1'b1;
        @(posedge clk); #1;
        instr_accept = 1'b0;
        wait_valid(n);
        checks++; if (n !== 11) begin errors++; $display("FAIL stall_resume_lat: got %0d expected 11", n); end
        checks++; if (instr !== 32'h694A0002 || instr_pc !== 8'h02) begin errors++; $display("FAIL stall_resume: got %h@%h expected 694a0002@02", instr, instr_pc); end
    endtask

    task automatic test_redirect_wait();
        int n;
        do_reset();
        repeat (4) @(posedge clk);
        #1;
        pc_load = 1'b1;
        pc_target = 8'hF5;
        @(posedge clk); #1;
        pc_load = 1'b0;
        wait_valid(n);
        checks++; if (n !== 11) begin errors++; $display("FAIL redir_wait_lat: got %0d expected 11", n); end
        checks++; if (instr_pc !== 8'hF5) begin errors++; $display("FAIL redir_wait_pc: got %h expected f5", instr_pc); end
        checks++; if (instr !== 32'h00080000) begin errors++; $display("FAIL redir_wait_instr: got %h expected 00080000", instr); end
    endtask

    task automatic test_wrap();
        int n;
        addr_q.delete();
        pc_load = 1'b1;
        pc_target = 8'hFE;
        @(posedge clk); #1;
        pc_load = 1'b0;
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL wrap_drop: got %b expected 0", instr_valid); end
        instr_accept = 1'b1;
        wait_valid(n);
        checks++; if (n !== lat(8'hFE)) begin errors++; $display("FAIL wrap_lat_fe: got %0d expected %0d", n, lat(8'hFE)); end
        checks++; if (instr_pc !== 8'hFE || instr !== word_pair(8'hFE)) begin errors++; $display("FAIL wrap_fe: got %h@%h expected %h@fe", instr, instr_pc, word_pair(8'hFE)); end
        @(posedge clk); #1;
        wait_valid(n);
        instr_accept = 1'b0;
        checks++; if (n !== lat(8'h00)) begin errors++; $display("FAIL wrap_lat_00: got %0d expected %0d", n, lat(8'h00)); end
        checks++; if (instr_pc !== 8'h00 || instr !== word_pair(8'h00)) begin errors++; $display("FAIL wrap_00: got %h@%h expected %h@00", instr, instr_pc, word_pair(8'h00)); end
        checks++;
        if (addr_q.size() !== 4 || addr_q[0] !== 8'hFE || addr_q[1] !== 8'hFF || addr_q[2] !== 8'h00 || addr_q[3] !== 8'h01) begin
            errors++;
            $display("FAIL wrap_addr_seq: got %0d requests %p expected FE FF 00 01", addr_q.size(), addr_q);
        end
    endtask

    task automatic test_load_accept();
        int n;
        pc_load = 1'b1;
        pc_target = 8'h04;
        instr_accept = 1'b1;
        @(posedge clk); #1;
        pc_load = 1'b0;
        instr_accept = 1'b0;
        wait_valid(n);
        checks++; if (n !== lat(8'h04)) begin errors++; $display("FAIL ldacc_lat: got %0d expected %0d", n, lat(8'h04)); end
        checks++; if (instr_pc !== 8'h04) begin errors++; $display("FAIL ldacc_pc: got %h expected 04", instr_pc); end
        checks++; if (instr !== word_pair(8'h04)) begin errors++; $display("FAIL ldacc_instr: got %h expected %h", instr, word_pair(8'h04)); end
    endtask

    task automatic test_reset_mid();
        int n;
        instr_accept = 1'b1;
        @(posedge clk); #1;
        instr_accept = 1'b0;
        @(posedge clk); #2;
        reset = 1'b0;
        #1;
        checks++; if (mem_start !== 1'b0 || instr_valid !== 1'b0) begin errors++; $display("FAIL midrst_ctl: got start=%b valid=%b expected 0 0", mem_start, instr_valid); end
        checks++; if (instr !== 32'd0 || instr_pc !== 8'd0 || mem_address !== 8'd0) begin errors++; $display("FAIL midrst_vals: got instr=%h pc=%h addr=%h expected 0 00 00", instr, instr_pc, mem_address); end
        @(posedge clk); #1;
        reset = 1'b1;
        wait_valid(n);
        checks++; if (n !== 7) begin errors++; $display("FAIL midrst_lat: got %0d expected 7", n); end
        checks++; if (instr !== word_pair(8'h00) || instr_pc !== 8'h00) begin errors++; $display("FAIL midrst_instr: got %h@%h expected %h@00", instr, instr_pc, word_pair(8'h00)); end
    endtask

    task automatic test_random();
        int n;
        int r;
        int d;
        bit lat_known;
        logic [7:0] exp_pc;
        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
        do_reset();
        exp_pc = 8'h00;
        lat_known = 1'b1;
        for (int it = 0; it < 40; it++) begin
            wait_valid(n);
            if (lat_known) begin
                checks++; if (n !== lat(exp_pc)) begin errors++; $display("FAIL rand_lat[%0d]: got %0d expected %0d", it, n, lat(exp_pc)); end
            end
            checks++; if (instr_pc !== exp_pc) begin errors++; $display("FAIL rand_pc[%0d]: got %h expected %h", it, instr_pc, exp_pc); end
            checks++; if (instr !== word_pair(exp_pc)) begin errors++; $display("FAIL rand_instr[%0d]: got %h expected %h", it, instr, word_pair(exp_pc)); end
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            r = $urandom_range(0, 3);
            lat_known = 1'b1;
            if (r == 0) begin
                pc_load = 1'b1;
                pc_target = 8'($urandom);
                instr_accept = 1'($urandom);
                exp_pc = pc_target;
            end else begin
                instr_accept = 1'b1;
                exp_pc = exp_pc + 8'd2;
            end
            @(posedge clk); #1;
            pc_load = 1'b0;
            instr_accept = 1'b0;
            if (r == 1) begin
                d = $urandom_range(1, lat(exp_pc) - 2);
                repeat (d) @(posedge clk);
                #1;
                pc_load = 1'b1;
                pc_target = 8'($urandom);
                exp_pc = pc_target;
                @(posedge clk); #1;
                pc_load = 1'b0;
                lat_known = 1'b0;
            end
        end
    endtask

    task automatic test_protocol();
        checks++; if (start_viol !== 0) begin errors++; $display("FAIL start_while_busy: got %0d occurrences expected 0", start_viol); end
        checks++; if (mem_rwn !== 1'b1) begin errors++; $display("FAIL mem_rwn: got %b expected 1", mem_rwn); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
        mem[8'h00] = 16'h6140;
        mem[8'h01] = 16'h0002;
        mem[8'h02] = 16'h694A;
        mem[8'h03] = 16'h0002;
        mem[8'h04] = 16'hA5C3;
        mem[8'h05] = 16'h3C5A;
        mem[8'hF5] = 16'h0008;
        mem[8'hF6] = 16'h0000;
        test_reset();
        test_basic();
        test_stall();
        test_redirect_wait();
        test_wrap();
        test_load_accept();
        test_reset_mid();
        test_random();
        test_protocol();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
